// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the flare32 core: holds the core in reset for an init period,
// runs it free-running or single-stepped, drains outstanding work and parks in Quit with status.
module cpu_run_ctrl #(
  parameter int STATE_WIDTH = 8,
  parameter int CNT_WIDTH   = 32,
  parameter int INIT_CYCLES = 4,
  parameter int MAX_CYCLES  = 0
) (
  input  logic                   __clk,
  input  logic                   __rst,
  input  logic                   __start,
  input  logic                   __halt_req,
  input  logic                   __step_mode,
  input  logic                   __step,
  input  logic                   __busy,
  output logic                   __core_en,
  output logic                   __core_rst,
  output logic [STATE_WIDTH-1:0] __state,
  output logic [CNT_WIDTH-1:0]   __cycle_cnt,
  output logic                   __done,
  output logic                   __timeout
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_QUIT  = 3'd5
  } state_t;

  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [ICW-1:0]       INIT_LOAD = ICW'(INIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_CYCLES);
  localparam bit                   TMO_EN    = (MAX_CYCLES != 0);

  state_t               state;
  logic [ICW-1:0]       init_cnt;
  logic                 halt_pend;
  logic                 step_mode_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 timeout_q;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 hit_max;

  assign __core_en   = (state == ST_RUN) | ((state == ST_STEP) & __step);
  assign __core_rst  = (state == ST_IDLE) | (state == ST_INIT);
  assign __done      = (state == ST_QUIT);
  assign __state     = STATE_WIDTH'(state);
  assign __cycle_cnt = cnt_q;
  assign __timeout   = timeout_q;

  assign cnt_inc = cnt_q + CNT_WIDTH'(1);
  assign hit_max = TMO_EN && (cnt_inc == MAX_CNT);

  always_ff @(posedge __clk) begin
    if (__rst) begin
      state       <= ST_IDLE;
      init_cnt    <= '0;
      halt_pend   <= 1'b0;
      step_mode_q <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_QUIT: begin
          if (__start) begin
            state       <= ST_INIT;
            init_cnt    <= INIT_LOAD;
            halt_pend   <= 1'b0;
            step_mode_q <= __step_mode;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
          end
        end
        ST_INIT: begin
          if (__halt_req) halt_pend <= 1'b1;
          // A halt on the last Init cycle must still divert to Drain.
          if (init_cnt == '0) begin
            if (halt_pend | __halt_req) state <= ST_DRAIN;
            else if (step_mode_q)       state <= ST_STEP;
            else                        state <= ST_RUN;
          end else begin
            init_cnt <= init_cnt - ICW'(1);
          end
        end
        ST_RUN, ST_STEP: begin
          if (__core_en) cnt_q <= cnt_inc;
          if (__core_en && hit_max) begin
            timeout_q <= 1'b1;
            state     <= ST_DRAIN;
          end else if (__halt_req) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!__busy) state <= ST_QUIT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Parametrised run-control sequencer for the flare32 core. It generalises the Init->Quit bench sequencer into a reusable block.
- Holds the core in reset for a configurable init period, then runs it free-running or single-stepped. Drains outstanding work on halt or timeout, then parks in Quit with status.
- Sits between the top-level harness/debug logic and the core's enable/reset inputs.

Parameters:
- STATE_WIDTH, 8, width of state encoding output
- CNT_WIDTH, 32, width of executed-cycle counter
- INIT_CYCLES, 4, cycles core reset is held in Init; legal range >=1
- MAX_CYCLES, 0, timeout on executed cycles; 0 disables timeout

Ports:
- __clk  input  1  clock; all logic on posedge
- __rst  input  1  synchronous active-high reset
- __start  input  1  begin sequence; honoured only in Idle or Quit
- __halt_req  input  1  request stop; level, sampled each cycle
- __step_mode  input  1  latched on accepted __start; 1 = single-step
- __step  input  1  in Step state, each high cycle = one core-enable cycle
- __busy  input  1  core has outstanding operation
- __core_en  output  1  core advance enable
- __core_rst  output  1  core reset
- __state  output  STATE_WIDTH  current state encoding
- __cycle_cnt  output  CNT_WIDTH  count of cycles with __core_en=1
- __done  output  1  sequence finished
- __timeout  output  1  sticky: finished due to MAX_CYCLES

Behaviour:
- Clock and reset: one clock __clk. __rst is synchronous and active-high.
- Reset values: __state=StIdle(0), __core_rst=1, __core_en=0, __cycle_cnt=0, __done=0, __timeout=0; internal init counter, halt_pend and step_mode latch cleared.
- Reset mid-operation: reset values appear on the cycle after __rst is sampled high, regardless of state.
- State encodings: StIdle=0, StInit=1, StRun=2, StStep=3, StDrain=4, StQuit=5. No other values reachable.
- Output decode from the registered state (no extra latency):
  - __core_rst=1 in Idle and Init.
  - __core_en = (state==Run) | (state==Step & __step).
  - __done=1 only in Quit.
- Idle: on __start, go to Init. The same edge latches __step_mode and loads the init counter.
- Init: lasts exactly INIT_CYCLES cycles.
  - __halt_req high on any Init cycle sets halt_pend.
  - At Init end: halt_pend=1 -> Drain; else step_mode latch=1 -> Step; else Run.
- Run/Step:
  - On each cycle with __core_en=1, __cycle_cnt increments by 1. With MAX_CYCLES=0 it wraps modulo 2^CNT_WIDTH.
  - Timeout: MAX_CYCLES!=0 and an increment makes the count equal MAX_CYCLES. Next state is Drain and __timeout is set.
  - __halt_req=1 -> Drain next cycle. The halt cycle itself still enables and counts if __core_en=1.
  - Halt and timeout on the same cycle: go to Drain and set __timeout (timeout takes priority for status).
- Drain: __core_en=0. Stay while __busy=1. When __busy=0, go to Quit next cycle, so minimum Drain dwell is 1 cycle.
- Quit:
  - Holds __cycle_cnt and __timeout; __done=1.
  - __start -> Init, clearing __cycle_cnt, __timeout and halt_pend, and relatching __step_mode.
- __start is ignored in Init/Run/Step/Drain. __halt_req is ignored in Idle/Drain/Quit. __step is ignored outside Step.

Test Plan:
- Basic run (INIT_CYCLES=4, MAX_CYCLES=0): __start pulse at cycle 0 -> __state=1 with __core_rst=1 for cycles 1-4; __state=2, __core_en=1 from cycle 5. Raise __halt_req at cycle 14 with __busy=0 -> __cycle_cnt=10, __state=4 at cycle 15, __state=5 and __done=1 at cycle 16.
- Timeout (MAX_CYCLES=16): start, no halt -> __core_en high exactly 16 cycles, then __cycle_cnt=16, __timeout=1, Drain, then Quit with __done=1.
- Single-step: __step_mode=1 at start, then 3 __step pulses separated by idle gaps, then __halt_req -> __core_en high only on the 3 step cycles; __cycle_cnt=3, __timeout=0.
- Drain hold: halt in Run with __busy=1 for 5 cycles -> __state=4 for 5 cycles plus 1, __core_en=0 throughout, then Quit.
- Halt during Init: __halt_req at cycle 2 -> Init still lasts 4 cycles, then Drain, then Quit with __cycle_cnt=0.
- Reset/restart:
  - __rst in Run at __cycle_cnt=7 -> next cycle all reset values.
  - Separate run ending in Quit with __timeout=1, then __start -> __cycle_cnt=0, __timeout=0, __state=1.
